key_repeat_scheduler: RTL

- Shares one command channel between NKEYS debounced/synchronized push-button levels.
- Grants one key at a time, round-robin. Issues one command on press, then auto-repeats while the key is held: first repeat after an initial delay, then at a fixed repeat rate.
- Enforces a post-release lockout gap. Sits between the per-key synchronizers and the project control FSM, which consumes commands via valid/ready.

---
 rtl/key_repeat_scheduler_if.sv | 15 +
 rtl/key_repeat_scheduler.sv | 118 +++++++++++
 2 files changed

// File: rtl/key_repeat_scheduler_if.sv
// Command channel between the key repeat scheduler (master) and the control FSM (slave).
// Valid/ready handshake carrying the granted key index and a repeat flag.
interface key_repeat_scheduler_if #(
  parameter int NKEYS = 4
);
  localparam int KW = (NKEYS > 1) ? $clog2(NKEYS) : 1;

  logic          CmdValid;
  logic          CmdReady;
  logic [KW-1:0] CmdKey;
  logic          CmdRepeat;

  modport master (output CmdValid, output CmdKey, output CmdRepeat, input CmdReady);
  modport slave  (input CmdValid, input CmdKey, input CmdRepeat, output CmdReady);
endinterface

// File: rtl/key_repeat_scheduler.sv
// Round-robin key arbiter with press command, delayed auto-repeat and post-release lockout.
// One key owns the command channel from grant until its release lockout expires.
module key_repeat_scheduler #(
  parameter int NKEYS      = 4,
  parameter int DELAY_CYC  = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000,
  parameter int GAP_CYC    = 500_000
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NKEYS-1:0]       Keys,
  key_repeat_scheduler_if.master cmd,
  output logic                   Busy
);
  localparam int KW   = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int CMAX = (DELAY_CYC > REPEAT_CYC)
                        ? ((DELAY_CYC > GAP_CYC) ? DELAY_CYC : GAP_CYC)
                        : ((REPEAT_CYC > GAP_CYC) ? REPEAT_CYC : GAP_CYC);
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] key_q, key_d;
  logic [KW-1:0] last_q, last_d;
  logic          rep_q, rep_d;
  logic [KW-1:0] grant_idx;
  logic          grant_found;

  // Round-robin: first set key above the last owner, otherwise wrap to the lowest set key.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int j = 0; j < NKEYS; j++) begin
      if (!grant_found && Keys[j] && (KW'(j) > last_q)) begin
        grant_found = 1'b1;
        grant_idx   = KW'(j);
      end
    end
    for (int j = 0; j < NKEYS; j++) begin
      if (!grant_found && Keys[j]) begin
        grant_found = 1'b1;
        grant_idx   = KW'(j);
      end
    end
  end

  // NOTE: every next-state variable gets its hold value first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    last_d  = last_q;
    rep_d   = rep_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d = ISSUE;
          key_d   = grant_idx;
          rep_d   = 1'b0;
        end
      end
      ISSUE: begin
        if (cmd.CmdReady) begin
          if (Keys[key_q]) begin
            state_d = HOLD;
            cnt_d   = rep_q ? CW'(REPEAT_CYC - 1) : CW'(DELAY_CYC - 1);
          end else begin
            state_d = GAP;
            cnt_d   = CW'(GAP_CYC);
            last_d  = key_q;
          end
        end
      end
      HOLD: begin
        // Release is checked first so it beats a simultaneous expiry.
        if (!Keys[key_q]) begin
          state_d = GAP;
          cnt_d   = CW'(GAP_CYC);
          last_d  = key_q;
        end else if (cnt_q == '0) begin
          state_d = ISSUE;
          rep_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      last_q  <= KW'(NKEYS - 1);
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      last_q  <= last_d;
      rep_q   <= rep_d;
    end
  end

  assign cmd.CmdValid  = (state_q == ISSUE);
  assign cmd.CmdKey    = key_q;
  assign cmd.CmdRepeat = rep_q;
  assign Busy          = (state_q != IDLE);
endmodule
